// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared defaults, channel state type and helpers for clk_div_multi
package clk_div_pkg;

    localparam int NCH_DEF   = 4;
    localparam int DIV_W_DEF = 8;

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_RUN,
        CH_DRAIN
    } ch_state_t;

    // Number of high cycles in a period of length r; odd ratios get the extra cycle high.
    function automatic int unsigned half_hi(input int unsigned r);
        return (r + 1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divider channel: state machine, period counter, active ratio, output registers
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div_val,
    input  logic             sync,
    input  logic             adv_in,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic             err,
    output logic             wrap_out
);

    localparam int HW = DIV_W + 1;

    ch_state_t        state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] r_act;
    logic [DIV_W-1:0] cnt_inc;
    logic [HW-1:0]    half;
    logic             legal;
    logic             active;
    logic             at_end;

    assign legal    = div_val > DIV_W'(1);
    assign active   = state != CH_IDLE;
    assign at_end   = cnt == r_act - DIV_W'(1);
    assign wrap_out = active && adv_in && at_end;
    assign cnt_inc  = cnt + DIV_W'(1);
    assign half     = HW'(half_hi(32'(r_act)));

    // Outputs are computed from the next count so they line up with the registered count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= CH_IDLE;
            cnt     <= '0;
            r_act   <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                CH_IDLE: begin
                    clk_out <= 1'b0;
                    tick    <= 1'b0;
                    busy    <= 1'b0;
                    if (en) begin
                        if (legal) begin
                            state   <= CH_RUN;
                            cnt     <= '0;
                            r_act   <= div_val;
                            clk_out <= 1'b1;
                            tick    <= 1'b1;
                            busy    <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (sync) begin
                        state   <= en ? CH_RUN : CH_DRAIN;
                        cnt     <= '0;
                        clk_out <= 1'b1;
                        tick    <= 1'b1;
                        busy    <= 1'b1;
                        if (legal) r_act <= div_val;
                        else       err   <= 1'b1;
                    end else if (wrap_out) begin
                        cnt <= '0;
                        if (en) begin
                            state   <= CH_RUN;
                            clk_out <= 1'b1;
                            tick    <= 1'b1;
                            if (legal) r_act <= div_val;
                            else       err   <= 1'b1;
                        end else begin
                            state   <= CH_IDLE;
                            clk_out <= 1'b0;
                            tick    <= 1'b0;
                            busy    <= 1'b0;
                        end
                    end else begin
                        state <= en ? CH_RUN : CH_DRAIN;
                        tick  <= 1'b0;
                        if (adv_in) begin
                            cnt     <= cnt_inc;
                            clk_out <= {1'b0, cnt_inc} < half;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable divider; CLK_DIV_CASCADE_EN chains channel i onto wraps of i-1
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NCH-1:0]       en,
    input  logic [NCH*DIV_W-1:0] div_val,
    input  logic                 sync,
    output logic [NCH-1:0]       clk_out,
    output logic [NCH-1:0]       tick,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       err
);

    logic [NCH-1:0] adv;
    logic [NCH-1:0] wrap;
    logic           unused_wrap;

    // The last wrap never feeds anything, and none do when channels run independently.
    assign unused_wrap = ^wrap;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
`ifdef CLK_DIV_CASCADE_EN
        if (i == 0) begin : g_root
            assign adv[i] = 1'b1;
        end else begin : g_link
            assign adv[i] = wrap[i-1];
        end
`else
        assign adv[i] = 1'b1;
`endif

        clk_div_chan #(
            .DIV_W(DIV_W)
        ) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (en[i]),
            .div_val (div_val[i*DIV_W +: DIV_W]),
            .sync    (sync),
            .adv_in  (adv[i]),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .busy    (busy[i]),
            .err     (err[i]),
            .wrap_out(wrap[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - directed and randomized bench for clk_div_multi against a period-position model
module tb_clk_div_multi;

    localparam int NCH   = 4;
    localparam int DIV_W = 8;

    logic                 clk     = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 sync    = 1'b0;
    logic [NCH-1:0]       en      = '0;
    logic [NCH*DIV_W-1:0] div_val = '0;
    logic [NCH-1:0]       clk_out;
    logic [NCH-1:0]       tick;
    logic [NCH-1:0]       busy;
    logic [NCH-1:0]       err;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: each channel is either active or not, sits at a position within a period of length m_len.
    bit m_act  [NCH];
    int m_pos  [NCH];
    int m_len  [NCH];
    bit m_tick [NCH];
    bit m_err  [NCH];

    clk_div_multi #(.NCH(NCH), .DIV_W(DIV_W)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (en),
        .div_val(div_val),
        .sync   (sync),
        .clk_out(clk_out),
        .tick   (tick),
        .busy   (busy),
        .err    (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_div(input int ch, input int r);
        div_val[ch*DIV_W +: DIV_W] = DIV_W'(r);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_act[i] = 0; m_pos[i] = 0; m_len[i] = 0; m_tick[i] = 0; m_err[i] = 0;
        end
    endtask

    task automatic model_step();
        int dv;
        bit adv;
        bit wr;
`ifdef CLK_DIV_CASCADE_EN
        bit prev_wrap;
        prev_wrap = 1'b0;
`endif
        for (int i = 0; i < NCH; i++) begin
            dv = int'(div_val[i*DIV_W +: DIV_W]);
            wr = 1'b0;
`ifdef CLK_DIV_CASCADE_EN
            adv = (i == 0) || prev_wrap;
`else
            adv = 1'b1;
`endif
            if (!m_act[i]) begin
                m_tick[i] = 0;
                if (en[i]) begin
                    if (dv >= 2) begin
                        m_act[i] = 1; m_pos[i] = 0; m_len[i] = dv; m_tick[i] = 1;
                    end else begin
                        m_err[i] = 1;
                    end
                end
            end else if (sync) begin
                m_pos[i] = 0; m_tick[i] = 1;
                if (dv >= 2) m_len[i] = dv; else m_err[i] = 1;
            end else if (adv && m_pos[i] == m_len[i] - 1) begin
                wr = 1'b1;
                m_pos[i] = 0;
                if (en[i]) begin
                    m_tick[i] = 1;
                    if (dv >= 2) m_len[i] = dv; else m_err[i] = 1;
                end else begin
                    m_act[i] = 0; m_tick[i] = 0;
                end
            end else begin
                m_tick[i] = 0;
                if (adv) m_pos[i]++;
            end
`ifdef CLK_DIV_CASCADE_EN
            prev_wrap = wr;
`endif
        end
    endtask

    task automatic check_all(input string tag);
        logic [NCH-1:0] e_clk, e_tick, e_busy, e_err;
        for (int i = 0; i < NCH; i++) begin
            e_busy[i] = m_act[i];
            e_clk[i]  = m_act[i] && (2 * m_pos[i] < m_len[i]);
            e_tick[i] = m_tick[i];
            e_err[i]  = m_err[i];
        end
        check({tag, "_clk"},  clk_out, e_clk);
        check({tag, "_tick"}, tick,    e_tick);
        check({tag, "_busy"}, busy,    e_busy);
        check({tag, "_err"},  err,     e_err);
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_clk", clk_out, 0);
        check("rst_tick", tick, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        reset_n = 1'b1;
        cyc("idle");

`ifdef CLK_DIV_CASCADE_EN
        set_div(0, 2); set_div(1, 3);
        en = 4'b0011;
        for (int k = 0; k <= 12; k++) begin
            cyc("casc");
            check("casc_tick1", tick[1], (k % 6) == 0);
        end
        en = '0;
        #2 reset_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
`endif

        // ch0 R=4: 1100 pattern, tick each fourth cycle
        set_div(0, 4);
        en[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc("t2");
            check("t2_clk0", clk_out[0], (k % 4) < 2);
            check("t2_tick0", tick[0], (k % 4) == 0);
        end

        // ch1 R=5 and ch2 R=2
        set_div(1, 5); set_div(2, 2);
        en[2:1] = 2'b11;
        for (int k = 0; k < 10; k++) begin
            cyc("t3");
            check("t3_clk1", clk_out[1], (k % 5) < 3);
            check("t3_clk2", clk_out[2], (k % 2) == 0);
        end

        // ch0 ratio change 4->6 at position 1
        for (int k = 0; k < 8 && m_pos[0] != 1; k++) cyc("t4w");
        set_div(0, 6);
        cyc("t4"); cyc("t4"); cyc("t4");
        check("t4_wrap_tick0", tick[0], 1);
        for (int k = 1; k < 6; k++) begin
            cyc("t4p");
            check("t4_clk0", clk_out[0], k < 3);
        end

        // ch3 R=8 drained from position 1
        set_div(3, 8);
        en[3] = 1'b1;
        cyc("t5"); cyc("t5");
        en[3] = 1'b0;
        for (int k = 0; k < 6; k++) cyc("t5d");
        check("t5_busy_last", busy[3], 1);
        cyc("t5e");
        check("t5_busy_done", busy[3], 0);
        check("t5_clk_done", clk_out[3], 0);

        // sync realigns ch0 R=3 and ch1 R=7 at arbitrary phases
        set_div(0, 3); set_div(1, 7);
        repeat ($urandom_range(3, 12)) cyc("t5s");
        sync = 1'b1;
        cyc("t5sync");
        sync = 1'b0;
        check("sync_tick", tick[1:0], 2'b11);
        check("sync_clk", clk_out[1:0], 2'b11);
        repeat (8) cyc("t5a");

        // illegal ratio on an idle channel
        set_div(3, 1);
        en[3] = 1'b1;
        cyc("t6");
        check("t6_err3", err[3], 1);
        check("t6_busy3", busy[3], 0);
        en[3] = 1'b0;
        set_div(3, 5);
        repeat (3) cyc("t6s");
        check("t6_err3_sticky", err[3], 1);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) en[$urandom_range(0, NCH - 1)] ^= 1'b1;
            if ($urandom_range(0, 7) == 0)
                set_div($urandom_range(0, NCH - 1),
                        ($urandom_range(0, 19) == 0) ? $urandom_range(0, 1) : $urandom_range(2, 12));
            sync = ($urandom_range(0, 29) == 0);
            cyc("rnd");
        end
        sync = 1'b0;

        // asynchronous reset in the middle of a period
        en = 4'b0001;
        set_div(0, 4);
        repeat (6) cyc("t1r");
        #2 reset_n = 1'b0;
        #1;
        check("t1_clk", clk_out, 0);
        check("t1_tick", tick, 0);
        check("t1_busy", busy, 0);
        check("t1_err", err, 0);
        model_reset();
        en = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        #1 check("t1_busy_rel", busy, 0);
        repeat (3) cyc("t1post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
